// File: rtl/commit_monitor_pkg.sv
// Shared constants for the commit monitor: state codes, default PC width and small helpers.
package commit_monitor_pkg;

  localparam int PC_WIDTH_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;
  localparam logic [1:0] ST_HANG = 2'b11;

  // Only IDLE and RUN can take a retirement; ERR and HANG hold until cleared.
  function automatic logic state_accepts(input logic [1:0] st);
    return (st == ST_IDLE) || (st == ST_RUN);
  endfunction

  function automatic int entry_width(input int pc_width);
    return 2 * pc_width;
  endfunction

endpackage

// File: rtl/commit_monitor_trace_fifo.sv
// Circular trace buffer: overwrite-oldest on full, show-ahead head, sticky overflow flag.
module trace_fifo
  import commit_monitor_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [AW:0]      count_r;
  logic             overflow_r;
  logic             full_s;
  logic             do_pop_s;

  // Full/empty qualification of the request lines.
  always_comb begin
    full_s   = (count_r == (AW+1)'(DEPTH));
    do_pop_s = pop && (count_r != '0);
  end

  // Storage is written at the tail on every push; no reset needed, reads are gated by count.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_r[tail_r] <= push_data;
    end
  end

  // Pointer, count and overflow bookkeeping; a push into a full buffer drops the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else if (clear) begin
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push) begin
        tail_r <= tail_r + AW'(1'b1);
      end
      if (push && do_pop_s) begin
        head_r <= head_r + AW'(1'b1);
      end else if (push && full_s) begin
        head_r     <= head_r + AW'(1'b1);
        overflow_r <= 1'b1;
      end else if (push) begin
        count_r <= count_r + (AW+1)'(1'b1);
      end else if (do_pop_s) begin
        head_r  <= head_r + AW'(1'b1);
        count_r <= count_r - (AW+1)'(1'b1);
      end
    end
  end

  assign rd_valid = (count_r != '0);
  assign rd_data  = rd_valid ? mem_r[head_r] : '0;
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/commit_monitor.sv
// Retirement-stream monitor: PC chain check, retirement counter, hang detection and a trace buffer.
module commit_monitor
  import commit_monitor_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH    = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   commit_i,
  input  logic [PC_WIDTH-1:0]    commit_pc_i,
  input  logic [PC_WIDTH-1:0]    commit_pre_pc_i,
  input  logic                   clear_i,
  input  logic                   rd_en_i,
  output logic                   rd_valid_o,
  output logic [PC_WIDTH-1:0]    rd_pc_o,
  output logic [PC_WIDTH-1:0]    rd_npc_o,
  output logic [$clog2(DEPTH):0] trace_cnt_o,
  output logic                   overflow_o,
  output logic [31:0]            commit_cnt_o,
  output logic [1:0]             state_o,
  output logic [PC_WIDTH-1:0]    err_pc_o,
  output logic [PC_WIDTH-1:0]    exp_pc_o
);

  localparam int EW = entry_width(PC_WIDTH);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [1:0]          state_r;
  logic [31:0]         commit_cnt_r;
  logic [PC_WIDTH-1:0] exp_pc_r;
  logic [PC_WIDTH-1:0] err_pc_r;
  logic [IW-1:0]       idle_r;
  logic                accept_s;
  logic                chain_ok_s;
  logic [EW-1:0]       rd_data_s;

  // The first commit out of IDLE skips the chain check.
  always_comb begin
    chain_ok_s = (state_r == ST_IDLE) || (commit_pc_i == exp_pc_r);
    accept_s   = commit_i && !clear_i && state_accepts(state_r) && chain_ok_s;
  end

  // FSM, counters and captured PCs; clear_i outranks any commit in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      commit_cnt_r <= 32'd0;
      exp_pc_r     <= '0;
      err_pc_r     <= '0;
      idle_r       <= '0;
    end else if (clear_i) begin
      state_r      <= ST_IDLE;
      commit_cnt_r <= 32'd0;
      exp_pc_r     <= '0;
      err_pc_r     <= '0;
      idle_r       <= '0;
    end else begin
      if (accept_s) begin
        commit_cnt_r <= commit_cnt_r + 32'd1;
        exp_pc_r     <= commit_pre_pc_i;
      end
      case (state_r)
        ST_IDLE: begin
          idle_r <= '0;
          if (commit_i) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (commit_i) begin
            idle_r <= '0;
            if (!chain_ok_s) begin
              state_r  <= ST_ERR;
              err_pc_r <= commit_pc_i;
            end
          end else if (idle_r >= IW'(TIMEOUT - 1)) begin
            // The TIMEOUT-th consecutive idle cycle ends the run.
            state_r <= ST_HANG;
            idle_r  <= '0;
          end else begin
            idle_r <= idle_r + IW'(1'b1);
          end
        end
        default: begin
          idle_r <= '0;
        end
      endcase
    end
  end

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_trace (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_i),
    .push      (accept_s),
    .push_data ({commit_pc_i, commit_pre_pc_i}),
    .pop       (rd_en_i),
    .rd_valid  (rd_valid_o),
    .rd_data   (rd_data_s),
    .count     (trace_cnt_o),
    .overflow  (overflow_o)
  );

  assign rd_pc_o      = rd_data_s[EW-1:PC_WIDTH];
  assign rd_npc_o     = rd_data_s[PC_WIDTH-1:0];
  assign commit_cnt_o = commit_cnt_r;
  assign state_o      = state_r;
  assign err_pc_o     = err_pc_r;
  assign exp_pc_o     = exp_pc_r;

endmodule

// File: tb/tb_commit_monitor.sv
// Self-checking bench: queue-based reference model compared every cycle, directed and random stimulus.
module tb_commit_monitor;

  localparam int PCW = 32;
  localparam int DEP = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit = 1'b0;
  logic [31:0] cpc = 32'd0;
  logic [31:0] cnpc = 32'd0;
  logic        clr = 1'b0;
  logic        rd = 1'b0;

  logic        rd_valid;
  logic [31:0] rd_pc, rd_npc, commit_cnt, err_pc, exp_pc;
  logic [2:0]  trace_cnt;
  logic        overflow;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b1;

  // Reference model state (0 IDLE, 1 RUN, 2 ERR, 3 HANG)
  int          m_state = 0;
  logic [31:0] m_cnt = 32'd0, m_exp = 32'd0, m_err = 32'd0;
  int          m_idle = 0;
  bit          m_ov = 1'b0;
  logic [31:0] qpc[$];
  logic [31:0] qnpc[$];

  always #5 clk = ~clk;

  commit_monitor #(.PC_WIDTH(PCW), .DEPTH(DEP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .commit_i(commit), .commit_pc_i(cpc), .commit_pre_pc_i(cnpc),
    .clear_i(clr), .rd_en_i(rd), .rd_valid_o(rd_valid), .rd_pc_o(rd_pc), .rd_npc_o(rd_npc),
    .trace_cnt_o(trace_cnt), .overflow_o(overflow), .commit_cnt_o(commit_cnt),
    .state_o(state), .err_pc_o(err_pc), .exp_pc_o(exp_pc)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_exp = 0; m_err = 0; m_idle = 0; m_ov = 0;
    qpc.delete(); qnpc.delete();
  endtask

  // Behavioural model of one clock edge
  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      model_reset();
    end else begin
      bit acc;
      acc = commit && (m_state == 0 || (m_state == 1 && cpc == m_exp));
      if (rd && qpc.size() > 0) begin
        void'(qpc.pop_front()); void'(qnpc.pop_front());
      end
      if (acc) begin
        qpc.push_back(cpc); qnpc.push_back(cnpc);
        if (qpc.size() > DEP) begin
          void'(qpc.pop_front()); void'(qnpc.pop_front());
          m_ov = 1;
        end
        m_cnt = m_cnt + 1;
        m_exp = cnpc;
      end
      if (m_state == 0 && commit) begin
        m_state = 1; m_idle = 0;
      end else if (m_state == 1) begin
        if (commit && !acc) begin
          m_state = 2; m_err = cpc;
        end else if (commit) begin
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle >= TMO) m_state = 3;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("state", state, m_state);
      cmp("commit_cnt", commit_cnt, m_cnt);
      cmp("exp_pc", exp_pc, m_exp);
      cmp("err_pc", err_pc, m_err);
      cmp("overflow", overflow, m_ov);
      cmp("trace_cnt", trace_cnt, qpc.size());
      cmp("rd_valid", rd_valid, qpc.size() != 0);
      cmp("rd_pc", rd_pc, (qpc.size() != 0) ? qpc[0] : 32'd0);
      cmp("rd_npc", rd_npc, (qnpc.size() != 0) ? qnpc[0] : 32'd0);
    end
  end

  task automatic drive(input bit c, input logic [31:0] pc, input logic [31:0] npc,
                       input bit cl, input bit r);
    @(negedge clk);
    commit = c; cpc = pc; cnpc = npc; clr = cl; rd = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp("reset_state", state, 2'd0);
    cmp("reset_cnt", commit_cnt, 32'd0);
    cmp("reset_tcnt", trace_cnt, 3'd0);
    cmp("reset_valid", rd_valid, 1'b0);

    // Basic chain
    drive(1, 32'h0, 32'h4, 0, 0);
    drive(1, 32'h4, 32'h8, 0, 0);
    drive(1, 32'h8, 32'h10, 0, 0);
    idle(1);
    cmp("t1_state", state, 2'd1);
    cmp("t1_cnt", commit_cnt, 32'd3);
    cmp("t1_tcnt", trace_cnt, 3'd3);
    cmp("t1_rd_pc", rd_pc, 32'h0);
    cmp("t1_rd_npc", rd_npc, 32'h4);

    // Chain break
    drive(1, 32'h14, 32'h18, 0, 0);
    idle(1);
    cmp("t2_state", state, 2'd2);
    cmp("t2_err_pc", err_pc, 32'h14);
    cmp("t2_cnt", commit_cnt, 32'd3);
    drive(1, 32'h10, 32'h14, 0, 0);
    idle(1);
    cmp("t2_ignored_cnt", commit_cnt, 32'd3);
    cmp("t2_ignored_tcnt", trace_cnt, 3'd3);

    // Clear with simultaneous commit while in ERR
    drive(1, 32'h100, 32'h104, 1, 0);
    idle(1);
    cmp("t5_state", state, 2'd0);
    cmp("t5_cnt", commit_cnt, 32'd0);
    cmp("t5_tcnt", trace_cnt, 3'd0);
    drive(1, 32'h200, 32'h204, 0, 0);
    idle(1);
    cmp("t5_accept_state", state, 2'd1);
    cmp("t5_accept_exp", exp_pc, 32'h204);

    // Hang timing: seven idle cycles survive, the eighth hangs
    idle(6);
    drive(1, 32'h204, 32'h208, 0, 0);
    idle(8);
    cmp("t3_run_at_7", state, 2'd1);
    idle(1);
    cmp("t3_hang_at_8", state, 2'd3);
    drive(1, 32'h208, 32'h20c, 0, 0);
    idle(1);
    cmp("t3_hang_cnt", commit_cnt, 32'd2);

    // Overwrite on full
    drive(0, 32'h0, 32'h0, 1, 0);
    for (int k = 0; k < 6; k++) drive(1, 32'(4 * k), 32'(4 * k + 4), 0, 0);
    idle(1);
    cmp("t4_tcnt", trace_cnt, 3'd4);
    cmp("t4_overflow", overflow, 1'b1);
    cmp("t4_head", rd_pc, 32'h8);
    for (int k = 0; k < 5; k++) drive(0, 32'h0, 32'h0, 0, 1);
    idle(1);
    cmp("t4_drained", trace_cnt, 3'd0);

    // Push and pop together on a full buffer
    drive(0, 32'h0, 32'h0, 1, 0);
    for (int k = 0; k < 4; k++) drive(1, 32'(4 * k), 32'(4 * k + 4), 0, 0);
    drive(1, 32'h10, 32'h14, 0, 1);
    idle(1);
    cmp("t4_pp_tcnt", trace_cnt, 3'd4);
    cmp("t4_pp_overflow", overflow, 1'b0);
    cmp("t4_pp_head", rd_pc, 32'h4);

    // Randomized traffic with alternating busy and quiet phases
    for (int i = 0; i < 3000; i++) begin
      bit c, cl, r;
      logic [31:0] pc, npc;
      if (i == 1500) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        cmp("t6_async_state", state, 2'd0);
        cmp("t6_async_cnt", commit_cnt, 32'd0);
        cmp("t6_async_tcnt", trace_cnt, 3'd0);
        cmp("t6_async_valid", rd_valid, 1'b0);
        cmp("t6_async_exp", exp_pc, 32'd0);
        drive(0, 32'h0, 32'h0, 0, 0);
        rst = 1'b0;
      end
      c  = ((i / 64) % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
      cl = ($urandom_range(0, 199) == 0) || ((m_state >= 2) && $urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 9) < 3);
      pc = (m_state == 1 && $urandom_range(0, 15) != 0) ? m_exp : 32'($urandom_range(0, 1023)) << 2;
      npc = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1023)) << 2 : pc + 32'd4;
      drive(c, pc, npc, cl, r);
    end
    idle(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
